// File: rtl/sim_video_expander_if.sv
// Video bundle between the core/harness and sim_video_expander.
// master drives pixel, strobes and ioctl; slave returns VGA_* and counters.
interface sim_video_expander_if #(
    parameter int BPP   = 1,
    parameter int OUT_W = 8
);
    logic [BPP-1:0]   pixel;
    logic             hsync;
    logic             vsync;
    logic             hblank;
    logic             vblank;
    logic             ioctl_download;
    logic [7:0]       ioctl_index;
    logic             ioctl_wr;
    logic [24:0]      ioctl_addr;
    logic [7:0]       ioctl_dout;
    logic [OUT_W-1:0] VGA_R;
    logic [OUT_W-1:0] VGA_G;
    logic [OUT_W-1:0] VGA_B;
    logic             VGA_HS;
    logic             VGA_VS;
    logic             VGA_HB;
    logic             VGA_VB;
    logic             VGA_DE;
    logic [11:0]      line_count;
    logic [15:0]      frame_count;

    modport master (
        output pixel, hsync, vsync, hblank, vblank,
        output ioctl_download, ioctl_index, ioctl_wr,
        output ioctl_addr, ioctl_dout,
        input  VGA_R, VGA_G, VGA_B,
        input  VGA_HS, VGA_VS, VGA_HB, VGA_VB, VGA_DE,
        input  line_count, frame_count
    );

    modport slave (
        input  pixel, hsync, vsync, hblank, vblank,
        input  ioctl_download, ioctl_index, ioctl_wr,
        input  ioctl_addr, ioctl_dout,
        output VGA_R, VGA_G, VGA_B,
        output VGA_HS, VGA_VS, VGA_HB, VGA_VB, VGA_DE,
        output line_count, frame_count
    );
endinterface

// File: rtl/sim_video_expander.sv
// Two-stage ce_pix-gated video output stage: BPP-bit index -> OUT_W-bit RGB.
// Ports: clk_sys, reset (async, active high), ce_pix, vid (slave bundle).
// Optional macro VIDEO_PALETTE_EN adds an ioctl-loadable RGB888 palette.
module sim_video_expander #(
    parameter int         BPP       = 1,
    parameter int         OUT_W     = 8,
    parameter logic [7:0] PAL_INDEX = 8'h02
) (
    input logic                 clk_sys,
    input logic                 reset,
    input logic                 ce_pix,
    sim_video_expander_if.slave vid
);
    localparam int ENTRIES = 1 << BPP;

    // Replicate the index bits MSB-first to fill 8 bits (full-scale grey).
    function automatic logic [7:0] grey(input logic [BPP-1:0] idx);
        logic [7:0] g;
        g = '0;
        for (int i = 0; i < 8; i++) begin
            g[7-i] = idx[BPP-1-(i % BPP)];
        end
        return g;
    endfunction

    logic [BPP-1:0]   s1_pix;
    logic             s1_hs, s1_vs, s1_hb, s1_vb;
    logic             prev_vs, prev_hb, prev_vb;
    logic [OUT_W-1:0] r_q, g_q, b_q;
    logic             hs_q, vs_q, hb_q, vb_q, de_q;
    logic [11:0]      line_q;
    logic [15:0]      frame_q;
    logic [23:0]      rgb;
    logic             blank;

`ifdef VIDEO_PALETTE_EN
    logic [23:0]    pal [ENTRIES];
    logic [24:0]    addr_hi;
    logic [BPP-1:0] wr_entry;
    logic           pal_we;

    assign addr_hi  = vid.ioctl_addr >> (BPP + 2);
    assign wr_entry = vid.ioctl_addr[BPP+1:2];
    assign pal_we   = vid.ioctl_download & vid.ioctl_wr
                    & (vid.ioctl_index == PAL_INDEX)
                    & (addr_hi == '0);

    // Independent of ce_pix; a same-edge lookup sees the old entry.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < ENTRIES; e++) begin
                pal[e] <= {3{grey(BPP'(e))}};
            end
        end else if (pal_we) begin
            case (vid.ioctl_addr[1:0])
                2'd0:    pal[wr_entry][23:16] <= vid.ioctl_dout;
                2'd1:    pal[wr_entry][15:8]  <= vid.ioctl_dout;
                2'd2:    pal[wr_entry][7:0]   <= vid.ioctl_dout;
                default: ;
            endcase
        end
    end

    assign rgb = pal[s1_pix];
`else
    assign rgb = {3{grey(s1_pix)}};
`endif

    assign blank = s1_hb | s1_vb;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            s1_pix  <= '0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_hb   <= 1'b0;
            s1_vb   <= 1'b0;
            prev_vs <= 1'b0;
            prev_hb <= 1'b0;
            prev_vb <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            hb_q    <= 1'b0;
            vb_q    <= 1'b0;
            de_q    <= 1'b0;
            line_q  <= '0;
            frame_q <= '0;
        end else if (ce_pix) begin
            s1_pix  <= vid.pixel;
            s1_hs   <= vid.hsync;
            s1_vs   <= vid.vsync;
            s1_hb   <= vid.hblank;
            s1_vb   <= vid.vblank;
            prev_vs <= s1_vs;
            prev_hb <= s1_hb;
            prev_vb <= s1_vb;
            r_q     <= blank ? '0 : rgb[23 -: OUT_W];
            g_q     <= blank ? '0 : rgb[15 -: OUT_W];
            b_q     <= blank ? '0 : rgb[7 -: OUT_W];
            hs_q    <= s1_hs;
            vs_q    <= s1_vs;
            hb_q    <= s1_hb;
            vb_q    <= s1_vb;
            de_q    <= ~blank;
            // A vblank rise clears the line count even if hblank rose too.
            if (s1_vb & ~prev_vb) begin
                line_q <= '0;
            end else if (s1_hb & ~prev_hb) begin
                line_q <= line_q + 12'd1;
            end
            if (s1_vs & ~prev_vs) begin
                frame_q <= frame_q + 16'd1;
            end
        end
    end

    assign vid.VGA_R       = r_q;
    assign vid.VGA_G       = g_q;
    assign vid.VGA_B       = b_q;
    assign vid.VGA_HS      = hs_q;
    assign vid.VGA_VS      = vs_q;
    assign vid.VGA_HB      = hb_q;
    assign vid.VGA_VB      = vb_q;
    assign vid.VGA_DE      = de_q;
    assign vid.line_count  = line_q;
    assign vid.frame_count = frame_q;
endmodule

// File: tb/tb_sim_video_expander.sv
// Self-checking bench for sim_video_expander (three parameter sets).
// Tables, hand sequences and a random run against a reference model.
module tb_sim_video_expander;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ce;
    logic [1:0]  pix;
    logic        hs, vs, hb, vb;
    logic        dl, wr;
    logic [7:0]  idx, dout;
    logic [24:0] addr;

    sim_video_expander_if #(.BPP(1), .OUT_W(8)) v1 ();
    sim_video_expander_if #(.BPP(2), .OUT_W(4)) v2 ();
    sim_video_expander_if #(.BPP(2), .OUT_W(8)) v3 ();

    assign {v1.pixel, v1.hsync, v1.vsync, v1.hblank, v1.vblank} =
           {pix[0], hs, vs, hb, vb};
    assign {v2.pixel, v2.hsync, v2.vsync, v2.hblank, v2.vblank} =
           {pix, hs, vs, hb, vb};
    assign {v3.pixel, v3.hsync, v3.vsync, v3.hblank, v3.vblank} =
           {pix, hs, vs, hb, vb};
    assign {v1.ioctl_download, v1.ioctl_index, v1.ioctl_wr,
            v1.ioctl_addr, v1.ioctl_dout} = {dl, idx, wr, addr, dout};
    assign {v2.ioctl_download, v2.ioctl_index, v2.ioctl_wr,
            v2.ioctl_addr, v2.ioctl_dout} = {dl, idx, wr, addr, dout};
    assign {v3.ioctl_download, v3.ioctl_index, v3.ioctl_wr,
            v3.ioctl_addr, v3.ioctl_dout} = {dl, idx, wr, addr, dout};

    sim_video_expander #(.BPP(1), .OUT_W(8)) d1 (
        .clk_sys(clk), .reset(rst), .ce_pix(ce), .vid(v1.slave));
    sim_video_expander #(.BPP(2), .OUT_W(4)) d2 (
        .clk_sys(clk), .reset(rst), .ce_pix(ce), .vid(v2.slave));
    sim_video_expander #(.BPP(2), .OUT_W(8)) d3 (
        .clk_sys(clk), .reset(rst), .ce_pix(ce), .vid(v3.slave));

    logic [63:0] got1, got2, got3;
    assign got1 = {7'd0, v1.VGA_R, v1.VGA_G, v1.VGA_B,
                   v1.VGA_HS, v1.VGA_VS, v1.VGA_HB, v1.VGA_VB, v1.VGA_DE,
                   v1.line_count, v1.frame_count};
    assign got2 = {19'd0, v2.VGA_R, v2.VGA_G, v2.VGA_B,
                   v2.VGA_HS, v2.VGA_VS, v2.VGA_HB, v2.VGA_VB, v2.VGA_DE,
                   v2.line_count, v2.frame_count};
    assign got3 = {7'd0, v3.VGA_R, v3.VGA_G, v3.VGA_B,
                   v3.VGA_HS, v3.VGA_VS, v3.VGA_HB, v3.VGA_VB, v3.VGA_DE,
                   v3.line_count, v3.frame_count};

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference model: each enabled edge pushes the sampled inputs; the
    // output after an edge reflects the sample taken one enabled edge earlier.
    typedef struct packed {
        logic [1:0] pix;
        logic hs, vs, hb, vb;
    } smp_t;

    smp_t       q0, q1;
    int         m_line, m_frame;
    logic [7:0] e1, e3;
    logic [3:0] e2;
    logic [4:0] eo;

    task automatic model_clear();
        q0 = '0; q1 = '0;
        m_line = 0; m_frame = 0;
        e1 = '0; e2 = '0; e3 = '0; eo = '0;
    endtask

    task automatic model_edge();
        smp_t cur;
        logic bl;
        cur = {pix, hs, vs, hb, vb};
        if (rst) begin
            model_clear();
        end else if (ce) begin
            if (q0.vb && !q1.vb) m_line = 0;
            else if (q0.hb && !q1.hb) m_line = (m_line + 1) % 4096;
            if (q0.vs && !q1.vs) m_frame = (m_frame + 1) % 65536;
            bl = q0.hb | q0.vb;
            e1 = bl ? 8'h00 : (q0.pix[0] ? 8'hFF : 8'h00);
            e3 = bl ? 8'h00 : 8'(int'(q0.pix) * 85);
            e2 = e3[7:4];
            eo = {q0.hs, q0.vs, q0.hb, q0.vb, ~bl};
            q1 = q0;
            q0 = cur;
        end
    endtask

    function automatic logic [63:0] exp1();
        return {7'd0, e1, e1, e1, eo, 12'(m_line), 16'(m_frame)};
    endfunction
    function automatic logic [63:0] exp2();
        return {19'd0, e2, e2, e2, eo, 12'(m_line), 16'(m_frame)};
    endfunction
    function automatic logic [63:0] exp3();
        return {7'd0, e3, e3, e3, eo, 12'(m_line), 16'(m_frame)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        tick();
        rst = 1'b0;
    endtask

    task automatic pal_wr(input logic d, input logic [7:0] i,
                          input logic [24:0] a, input logic [7:0] v);
        dl = d; idx = i; addr = a; dout = v; wr = 1'b1;
        tick();
        wr = 1'b0; dl = 1'b0;
    endtask

    typedef struct {
        logic [1:0] pix;
        logic       hb, vb;
        logic [7:0] r1;
        logic [3:0] r2;
        logic       de;
    } vec_t;

    vec_t vt [6];

    logic [23:0] pal_a, pal_b, grey3;
    int          n_en;

    initial begin
        rst = 1'b1; ce = 1'b1; pix = '0;
        hs = 0; vs = 0; hb = 0; vb = 0;
        dl = 0; wr = 0; idx = '0; addr = '0; dout = '0;
        model_clear();
        #2;
        check("reset_d1", got1, 64'd0);
        check("reset_d2", got2, 64'd0);
        check("reset_d3", got3, 64'd0);
        do_reset();

        // Steady-state colour table.
        vt[0] = '{2'b01, 0, 0, 8'hFF, 4'h5, 1};
        vt[1] = '{2'b00, 0, 0, 8'h00, 4'h0, 1};
        vt[2] = '{2'b10, 0, 0, 8'h00, 4'hA, 1};
        vt[3] = '{2'b10, 1, 0, 8'h00, 4'h0, 0};
        vt[4] = '{2'b11, 0, 1, 8'h00, 4'h0, 0};
        vt[5] = '{2'b11, 0, 0, 8'hFF, 4'hF, 1};
        for (int i = 0; i < 6; i++) begin
            pix = vt[i].pix; hb = vt[i].hb; vb = vt[i].vb;
            tick(); tick();
            check($sformatf("tbl%0d_d1", i),
                  {v1.VGA_R, v1.VGA_G, v1.VGA_B, v1.VGA_DE},
                  {vt[i].r1, vt[i].r1, vt[i].r1, vt[i].de});
            check($sformatf("tbl%0d_d2", i),
                  {v2.VGA_R, v2.VGA_G, v2.VGA_B, v2.VGA_HB, v2.VGA_DE},
                  {vt[i].r2, vt[i].r2, vt[i].r2, vt[i].hb, vt[i].de});
        end

        // hblank and colour change on the same output edge.
        pix = 2'b10; hb = 0; vb = 0;
        tick(); tick();
        hb = 1;
        tick();
        check("hb_align_1", {v2.VGA_R, v2.VGA_HB}, {4'hA, 1'b0});
        tick();
        check("hb_align_2", {v2.VGA_R, v2.VGA_HB}, {4'h0, 1'b1});
        hb = 0;

        // ce_pix one-in-four: latency is two enabled edges.
        pix = 2'b00;
        tick(); tick();
        pix = 2'b01;
        n_en = 0;
        for (int c = 0; c < 12; c++) begin
            ce = (c % 4 == 3);
            tick();
            if (ce) n_en++;
            check($sformatf("ce_lat%0d", c), 64'(v1.VGA_R),
                  (n_en >= 2) ? 64'hFF : 64'h00);
        end
        ce = 1'b1;

        // Counters.
        pix = '0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            vs = 1; tick(); vs = 0; tick();
        end
        for (int i = 0; i < 10; i++) begin
            hb = 1; tick(); hb = 0; tick();
        end
        tick(); tick();
        check("frame_3", 64'(v1.frame_count), 64'd3);
        check("line_10", 64'(v1.line_count), 64'd10);
        vb = 1;
        tick();
        check("line_hold", 64'(v1.line_count), 64'd10);
        tick();
        check("line_clr", 64'(v1.line_count), 64'd0);
        vb = 0; tick(); tick();
        hb = 1; tick(); hb = 0; tick(); tick();
        check("line_1", 64'(v1.line_count), 64'd1);
        hb = 1; vb = 1;
        tick(); tick();
        check("line_both", 64'(v3.line_count), 64'd0);
        hb = 0; vb = 0;

        // Strobe already high when reset releases counts as a rise.
        rst = 1'b1; hb = 1;
        model_clear();
        tick();
        rst = 1'b0;
        tick(); tick();
        check("rel_edge", 64'(v1.line_count), 64'd1);
        hb = 0;

        // Palette loading and ignored writes.
`ifdef VIDEO_PALETTE_EN
        pal_a = 24'h123456;
        pal_b = 24'h773456;
`else
        pal_a = 24'h555555;
        pal_b = 24'h555555;
`endif
        grey3 = 24'h555555;
        do_reset();
        pix = 2'b01;
        pal_wr(1, 8'h02, 25'd4, 8'h12);
        pal_wr(1, 8'h02, 25'd5, 8'h34);
        pal_wr(1, 8'h02, 25'd6, 8'h56);
        pal_wr(1, 8'h02, 25'd7, 8'hFF);
        pal_wr(1, 8'h02, 25'h40005, 8'hFF);
        pal_wr(0, 8'h02, 25'd6, 8'hFF);
        tick();
        check("pal_load", {v3.VGA_R, v3.VGA_G, v3.VGA_B}, pal_a);
        pal_wr(1, 8'h02, 25'd4, 8'h77);
        check("pal_same_edge", {v3.VGA_R, v3.VGA_G, v3.VGA_B}, pal_a);
        tick();
        check("pal_next_edge", {v3.VGA_R, v3.VGA_G, v3.VGA_B}, pal_b);

        // Async reset mid-line with the palette loaded.
        hb = 1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_d1", got1, 64'd0);
        check("async_d2", got2, 64'd0);
        check("async_d3", got3, 64'd0);
        model_clear();
        tick();
        rst = 1'b0; hb = 0;
        tick(); tick();
        check("post_rst_grey", {v3.VGA_R, v3.VGA_G, v3.VGA_B}, grey3);
        pal_wr(1, 8'h00, 25'd4, 8'h12);
        tick();
        check("wrong_index", {v3.VGA_R, v3.VGA_G, v3.VGA_B}, grey3);

        // Random run against the model.
        pix = '0;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            pix = 2'($urandom_range(0, 3));
            hs  = ($urandom_range(0, 3) == 0);
            vs  = ($urandom_range(0, 7) == 0);
            hb  = ($urandom_range(0, 2) == 0);
            vb  = ($urandom_range(0, 9) == 0);
            ce  = (n < 400) ? 1'b1 : ($urandom_range(0, 3) == 0);
            dl  = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            idx = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h03;
            addr = 25'($urandom_range(0, 15));
            dout = 8'($urandom);
            tick();
            check($sformatf("rnd%0d_d1", n), got1, exp1());
            check($sformatf("rnd%0d_d2", n), got2, exp2());
            check($sformatf("rnd%0d_d3", n), got3, exp3());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sim_video_expander.md
# sim_video_expander

Parametrised video output stage for the Verilator simulation top and the MiSTer wrapper: takes the core's N-bit pixel index plus sync/blank strobes and produces registered, pipeline-aligned VGA_R/G/B, sync, blank and data-enable. It replaces the fixed 1bpp-to-8bpp mono conversion with a BPP-wide index, an optional ioctl-loadable RGB palette, blank forcing, and frame/line counters for the sim harness. It sits between the core's video outputs and the top-level VGA_* ports.

## Interface
Parameters:
- BPP, 1, pixel index width (legal 1..4)
- OUT_W, 8, output colour width per channel (legal 4..8)
- PAL_INDEX, 8'h02, ioctl_index value that selects palette download

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce_pix  in  1  pixel clock enable; pipeline advances only when high
- pixel  in  BPP  pixel index from core
- hsync, vsync, hblank, vblank  in  1 each  core timing strobes
- ioctl_download  in  1  download active
- ioctl_index  in  8  download target
- ioctl_wr  in  1  download byte strobe
- ioctl_addr  in  25  download byte address
- ioctl_dout  in  8  download byte
- VGA_R, VGA_G, VGA_B  out  OUT_W  colour outputs
- VGA_HS, VGA_VS, VGA_HB, VGA_VB  out  1 each  delayed timing
- VGA_DE  out  1  ~(VGA_HB | VGA_VB), registered
- line_count  out  12  active line counter
- frame_count  out  16  frame counter

## Operation
- Two-stage pipeline, both stages gated by ce_pix.
- Stage 1: register pixel, hsync, vsync, hblank, vblank.
- Stage 2: colour lookup on stage-1 index; register RGB and stage-1 timing to outputs.
- Blank forcing: if stage-1 hblank or vblank is 1, RGB outputs are 0 regardless of index.
- Lookup without palette: each channel = 8-bit grey value formed by replicating the index bits to 8 bits (BPP=1: 0->8'h00, 1->8'hFF; BPP=2: 2'b10->8'hAA).
- Width rule: 8-bit channel value reduced to OUT_W by taking its top OUT_W bits.
- line_count: increments on stage-1 hblank rising edge (sampled on ce_pix); cleared to 0 on stage-1 vblank rising edge; if both occur in the same sample, clear wins. Wraps at 4095->0.
- frame_count: increments on stage-1 vsync rising edge; wraps 16'hFFFF->0.
- Edge detection uses the previous stage-1 value, updated only on ce_pix.

## Timing
- Reset (async assert): all outputs 0, both counters 0, pipeline registers 0, edge history 0, palette returns to grey ramp.
- Latency: pixel/timing input to VGA_* output = 2 ce_pix-qualified clk_sys edges; colour and sync always stay aligned.
- ce_pix low: all pipeline registers and counters hold.
- Reset deassertion mid-frame: first edge history is 0, so a strobe already high on the first sample counts as a rising edge.
- Palette writes are independent of ce_pix and take effect on the next clk_sys edge; a write and a stage-2 lookup of the same entry on the same edge returns the old value.
- Writes with ioctl_download low or ioctl_index != PAL_INDEX are ignored.

## Configuration
- VIDEO_PALETTE_EN defined: 2^BPP-entry palette of 24-bit RGB888 registers, reset to the grey ramp. ioctl byte write when ioctl_download & ioctl_wr & ioctl_index==PAL_INDEX: entry = ioctl_addr[BPP+1:2], ioctl_addr[1:0] selects 0=R, 1=G, 2=B, 3=ignored; addresses with ioctl_addr[24:BPP+2] non-zero ignored. Lookup uses the palette entry per channel.
- VIDEO_PALETTE_EN undefined: no palette storage; ioctl ports unused; lookup is grey replication only.

## Test plan
- BPP=1, OUT_W=8, no macro, ce_pix=1, pixel=1 active -> VGA_R/G/B=8'hFF two clocks later, VGA_DE=1; pixel=0 -> 8'h00.
- BPP=2, OUT_W=4, pixel=2'b10 active -> RGB=4'hA; same pixel with hblank=1 -> RGB=0, VGA_HB=1 aligned with the colour change.
- VIDEO_PALETTE_EN, BPP=2: write addr 4,5,6 = 8'h12,8'h34,8'h56 at PAL_INDEX, then pixel=1 -> R=8'h12, G=8'h34, B=8'h56; same write with ioctl_index=0 -> grey 8'h55 kept.
- ce_pix toggling 1-of-4: outputs change only on ce_pix edges, latency exactly 2 enabled edges.
- 3 vsync pulses, 10 hblank pulses, then vblank rise -> frame_count=3, line_count 10 then 0; hblank and vblank rising together -> line_count=0.
- Assert reset mid-line with palette loaded -> all outputs and counters 0 immediately; after release, pixel=1 (BPP=2) -> grey 8'h55.
